game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter FRAME_H_END, default 799, last hCount of a frame.
REQ-002 Parameter FRAME_V_END, default 524, last vCount of a frame.
REQ-003 Parameter SCORE_DIV, default 6, frames per score point (range 1..63).
REQ-004 Parameter LEVEL_STEP, default 100, score points per level increment (range 1..1023).
REQ-005 Parameter LEVEL_MAX, default 7, level saturation value (range 0..7).
REQ-006 clk  in  1  system/pixel clock; rising-edge active.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  start/restart button, synchronous to clk, already debounced.
REQ-009 hCount  in  10  horizontal pixel counter from the display controller.
REQ-010 vCount  in  10  vertical line counter from the display controller.
REQ-011 bright  in  1  display-area indicator.
REQ-012 rex_fill  in  1  player sprite covers the current pixel.
REQ-013 obst_fill  in  1  obstacle sprite covers the current pixel.
REQ-014 frame_tick  out  1  one-cycle pulse per frame.
REQ-015 run  out  1  high in RUN state; gates player/obstacle motion.
REQ-016 game_over  out  1  high in OVER state.
REQ-017 score  out  16  current score.
REQ-018 level  out  3  current difficulty level.
REQ-019 hiscore  out  16  best score (see Configuration).

Function
REQ-020 frame_tick SHALL assert for exactly one cycle, on the cycle after hCount==FRAME_H_END && vCount==FRAME_V_END is sampled.
REQ-021 start SHALL be edge-detected internally; only a 0->1 transition (start_rise) acts as a command.
REQ-022 FSM states IDLE, RUN, OVER: IDLE->RUN on start_rise; RUN->OVER on frame_tick with hit_latch set; OVER->IDLE on start_rise; all other conditions hold state.
REQ-023 start_rise in RUN SHALL be ignored.
REQ-024 hit_latch SHALL set in any RUN cycle with bright && rex_fill && obst_fill, and SHALL clear on every frame_tick.
REQ-025 Collision pixels outside bright, or outside RUN, SHALL NOT set hit_latch.
REQ-026 On the IDLE->RUN transition, score, level, frame_cnt, pts_cnt and hit_latch SHALL clear to 0.
REQ-027 In RUN, frame_cnt SHALL count frame_ticks 0..SCORE_DIV-1; on wrap, score SHALL increment by 1, saturating at 16'hFFFF.
REQ-028 pts_cnt SHALL count score increments 0..LEVEL_STEP-1; on wrap, level SHALL increment, saturating at LEVEL_MAX.
REQ-029 If hit_latch and a score increment coincide on one frame_tick, the hit SHALL win and score SHALL NOT increment.
REQ-030 score and level SHALL hold their values in OVER and IDLE until the next IDLE->RUN.
REQ-031 run and game_over SHALL be registered decodes of the state; the state change is visible one cycle after the qualifying event.

Reset
REQ-032 Asynchronous rst SHALL force IDLE, with frame_tick, run, game_over, score, level, hiscore, hit_latch, all counters and the start edge register at 0.
REQ-033 rst asserted mid-RUN SHALL abandon the game; hiscore is not updated.

Configuration
REQ-034 Macro GAME_SEQUENCER_HISCORE_EN defined: on RUN->OVER, hiscore SHALL load max(hiscore, score), with the comparison using the final score.
REQ-035 Macro undefined: the hiscore port SHALL remain present and be tied to 0, with no comparator or register.

Structure
REQ-036 Package game_pkg SHALL hold the state enum (IDLE/RUN/OVER), SCORE_W=16, LEVEL_W=3 and the default frame constants.
REQ-037 Sub-module frame_tick_gen SHALL implement REQ-020; all other logic stays in game_sequencer.

Verification (SCORE_DIV=2, LEVEL_STEP=3, LEVEL_MAX=2, small frame timing)
REQ-038 Idle 3 frames, then start pulse -> run=1 one cycle later; score=0; 6 frames -> score=3, level=1.
REQ-039 Overlap rex_fill/obst_fill with bright=1 in frame 4 -> game_over=1 one cycle after that frame's tick; score frozen.
REQ-040 Overlap with bright=0 only -> no state change; score keeps counting.
REQ-041 Hit in the frame where a score increment is due -> OVER entered, score not incremented.
REQ-042 Run to 20 points -> level saturates at 2; start held high during RUN -> no effect; OVER then start -> IDLE, next start -> score=0.
REQ-043 With HISCORE_EN: games scoring 5 then 3 -> hiscore=5; rst mid-game -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the game sequencer slice: FSM state
// encoding, score/level widths and the default frame geometry.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int SCORE_W         = 16;
    localparam int LEVEL_W         = 3;
    localparam int PIX_W           = 10;
    localparam int FRAME_H_END_DEF = 799;
    localparam int FRAME_V_END_DEF = 524;

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of the display-side inputs and game-status outputs of the
// sequencer. The master side (display/controller) drives the pixel and
// button signals; the slave side (game_sequencer) drives status.
interface game_sequencer_if;
    import game_pkg::*;

    logic                 start;
    logic [PIX_W-1:0]     hCount;
    logic [PIX_W-1:0]     vCount;
    logic                 bright;
    logic                 rex_fill;
    logic                 obst_fill;
    logic                 frame_tick;
    logic                 run;
    logic                 game_over;
    logic [SCORE_W-1:0]   score;
    logic [LEVEL_W-1:0]   level;
    logic [SCORE_W-1:0]   hiscore;

    modport master (
        output start, hCount, vCount, bright, rex_fill, obst_fill,
        input  frame_tick, run, game_over, score, level, hiscore
    );

    modport slave (
        input  start, hCount, vCount, bright, rex_fill, obst_fill,
        output frame_tick, run, game_over, score, level, hiscore
    );

endinterface

// File: rtl/game_sequencer_frame_tick_gen.sv
// Produces a single-cycle pulse one cycle after the last pixel of a frame
// has been seen on the display counters.
module frame_tick_gen
    import game_pkg::*;
#(
    parameter int FRAME_H_END = FRAME_H_END_DEF,
    parameter int FRAME_V_END = FRAME_V_END_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] h_count,
    input  logic [PIX_W-1:0] v_count,
    output logic             frame_tick
);

    localparam logic [PIX_W-1:0] H_LAST = PIX_W'(FRAME_H_END);
    localparam logic [PIX_W-1:0] V_LAST = PIX_W'(FRAME_V_END);

    // Register the end-of-frame match so the pulse lands on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (h_count == H_LAST) && (v_count == V_LAST);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: IDLE/RUN/OVER control, collision latch, frame-based
// scoring and level progression for the runner game.
// Optional feature: define GAME_SEQUENCER_HISCORE_EN to keep a best-score
// register; otherwise the hiscore port is tied to zero.
module game_sequencer
    import game_pkg::*;
#(
    parameter int FRAME_H_END = FRAME_H_END_DEF,
    parameter int FRAME_V_END = FRAME_V_END_DEF,
    parameter int SCORE_DIV   = 6,
    parameter int LEVEL_STEP  = 100,
    parameter int LEVEL_MAX   = 7
) (
    input  logic            clk,
    input  logic            rst,
    game_sequencer_if.slave bus
);

    localparam logic [5:0]         FRAME_LAST = 6'(SCORE_DIV - 1);
    localparam logic [9:0]         PTS_LAST   = 10'(LEVEL_STEP - 1);
    localparam logic [LEVEL_W-1:0] LVL_TOP    = LEVEL_W'(LEVEL_MAX);
    localparam logic [SCORE_W-1:0] SCORE_TOP  = '1;

    game_state_t        state;
    game_state_t        state_n;
    logic               frame_tick;
    logic               start_q;
    logic               start_rise;
    logic               collide;
    logic               begin_game;
    logic               game_end;
    logic               frame_adv;
    logic               hit_latch;
    logic [5:0]         frame_cnt;
    logic [9:0]         pts_cnt;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;
    logic               run_q;
    logic               over_q;

    frame_tick_gen #(
        .FRAME_H_END (FRAME_H_END),
        .FRAME_V_END (FRAME_V_END)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .h_count    (bus.hCount),
        .v_count    (bus.vCount),
        .frame_tick (frame_tick)
    );

    assign start_rise = bus.start & ~start_q;
    assign collide    = bus.bright & bus.rex_fill & bus.obst_fill;
    assign begin_game = (state == IDLE) && start_rise;
    assign game_end   = (state == RUN) && frame_tick && hit_latch;
    assign frame_adv  = (state == RUN) && frame_tick && !hit_latch;

    // Remember the previous button level so only rising edges act as commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= bus.start;
        end
    end

    // Game state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: start launches or dismisses a game, a latched hit ends it at frame end.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_rise) state_n = RUN;
            RUN:     if (frame_tick && hit_latch) state_n = OVER;
            OVER:    if (start_rise) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status flags decode the upcoming state so they change together with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            over_q <= 1'b0;
        end else begin
            run_q  <= (state_n == RUN);
            over_q <= (state_n == OVER);
        end
    end

    // Collision latch: any visible overlap while running, forgotten at each frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_latch <= 1'b0;
        end else if (begin_game) begin
            hit_latch <= 1'b0;
        end else begin
            hit_latch <= (hit_latch && !frame_tick) || ((state == RUN) && collide);
        end
    end

    // Score every SCORE_DIV survived frames and raise the level every LEVEL_STEP points.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            pts_cnt   <= '0;
            score     <= '0;
            level     <= '0;
        end else if (begin_game) begin
            frame_cnt <= '0;
            pts_cnt   <= '0;
            score     <= '0;
            level     <= '0;
        end else if (frame_adv) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                if (score != SCORE_TOP) begin
                    score <= score + 16'd1;
                end
                if (pts_cnt == PTS_LAST) begin
                    pts_cnt <= '0;
                    if (level != LVL_TOP) begin
                        level <= level + 3'd1;
                    end
                end else begin
                    pts_cnt <= pts_cnt + 10'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

`ifdef GAME_SEQUENCER_HISCORE_EN
    logic [SCORE_W-1:0] hiscore;

    // Keep the best final score, captured as a game ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hiscore <= '0;
        end else if (game_end && (score > hiscore)) begin
            hiscore <= score;
        end
    end

    assign bus.hiscore = hiscore;
`else
    assign bus.hiscore = '0;
`endif

    assign bus.frame_tick = frame_tick;
    assign bus.run        = run_q;
    assign bus.game_over  = over_q;
    assign bus.score      = score;
    assign bus.level      = level;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer with a tiny 8x4 frame. Stimulus is
// generated a frame at a time; a frame-level reference model predicts the
// status after each frame boundary and a monitor checks it.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int H_END      = 7;
    localparam int V_END      = 3;
    localparam int SCORE_DIV  = 2;
    localparam int LEVEL_STEP = 3;
    localparam int LEVEL_MAX  = 2;

    typedef struct {
        int run;
        int over;
        int score;
        int level;
        int hiscore;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   check_count = 0;
    int   pass_count  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic tick_prev = 1'b0;

    // Reference model: 0 = waiting, 1 = playing, 2 = game finished.
    int m_mode    = 0;
    int m_frames  = 0;
    int m_hiscore = 0;
    bit m_hit     = 0;

    game_sequencer_if bus();

    game_sequencer #(
        .FRAME_H_END (H_END),
        .FRAME_V_END (V_END),
        .SCORE_DIV   (SCORE_DIV),
        .LEVEL_STEP  (LEVEL_STEP),
        .LEVEL_MAX   (LEVEL_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int modelScore();
        int s;
        s = m_frames / SCORE_DIV;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic int modelLevel();
        int l;
        l = modelScore() / LEVEL_STEP;
        return (l > LEVEL_MAX) ? LEVEL_MAX : l;
    endfunction

    function automatic int modelHiscore();
`ifdef GAME_SEQUENCER_HISCORE_EN
        return m_hiscore;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Frame boundary in the model: a hit ends the game, otherwise a survived frame counts.
    task automatic modelFrameEnd();
        exp_t e;
        if (m_mode == 1) begin
            if (m_hit) begin
                m_mode = 2;
                if (modelScore() > m_hiscore) m_hiscore = modelScore();
            end else begin
                m_frames++;
            end
        end
        m_hit     = 0;
        e.run     = (m_mode == 1);
        e.over    = (m_mode == 2);
        e.score   = modelScore();
        e.level   = modelLevel();
        e.hiscore = modelHiscore();
        exp_q.push_back(e);
    endtask

    // One full frame of pixels with optional start press, collisions and a mid-frame reset.
    task automatic applyStimulus(input bit do_start, input bit hold, input bit hit_b,
                                 input bit hit_d, input bit do_rst);
        for (int v = 0; v <= V_END; v++) begin
            for (int h = 0; h <= H_END; h++) begin
                @(posedge clk);
                #1;
                bus.hCount    = 10'(h);
                bus.vCount    = 10'(v);
                bus.bright    = (h < 6) && (v < 3);
                bus.rex_fill  = 1'($urandom_range(0, 1));
                bus.obst_fill = !bus.rex_fill && ($urandom_range(0, 1) == 1);
                bus.start     = do_start && (hold ? (v > 0 || h >= 2) : (v == 0 && h == 2));
                if (do_start && v == 0 && h == 2) begin
                    if (m_mode == 0) begin
                        m_mode   = 1;
                        m_frames = 0;
                        m_hit    = 0;
                    end else if (m_mode == 2) begin
                        m_mode = 0;
                    end
                end
                if (hit_b && v == 1 && h == 3) begin
                    bus.rex_fill  = 1'b1;
                    bus.obst_fill = 1'b1;
                    if (m_mode == 1) m_hit = 1;
                end
                if (hit_d && v == 1 && h == 6) begin
                    bus.rex_fill  = 1'b1;
                    bus.obst_fill = 1'b1;
                end
                if (do_start && v == 0 && h == 3) begin
                    @(negedge clk);
                    checkOutput("start_run", int'(bus.run), int'(m_mode == 1));
                    checkOutput("start_over", int'(bus.game_over), int'(m_mode == 2));
                end
                if (do_rst && v == 1 && h == 4) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    checkOutput("arst_run", int'(bus.run), 0);
                    checkOutput("arst_over", int'(bus.game_over), 0);
                    checkOutput("arst_score", int'(bus.score), 0);
                    checkOutput("arst_level", int'(bus.level), 0);
                    checkOutput("arst_hiscore", int'(bus.hiscore), 0);
                    m_mode    = 0;
                    m_frames  = 0;
                    m_hit     = 0;
                    m_hiscore = 0;
                    #3;
                    rst = 1'b0;
                end
                if (v == V_END && h == H_END) modelFrameEnd();
            end
        end
    endtask

    // Monitor: the cycle after each frame tick, compare status with the oldest prediction.
    always @(negedge clk) begin
        if (tick_prev) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_tick", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("frame_run", int'(bus.run), mon_e.run);
                checkOutput("frame_over", int'(bus.game_over), mon_e.over);
                checkOutput("frame_score", int'(bus.score), mon_e.score);
                checkOutput("frame_level", int'(bus.level), mon_e.level);
                checkOutput("frame_hiscore", int'(bus.hiscore), mon_e.hiscore);
            end
        end
        tick_prev = bus.frame_tick;
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.hCount    = '0;
        bus.vCount    = '0;
        bus.bright    = 1'b0;
        bus.rex_fill  = 1'b0;
        bus.obst_fill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tick", int'(bus.frame_tick), 0);
        checkOutput("rst_run", int'(bus.run), 0);
        checkOutput("rst_over", int'(bus.game_over), 0);
        checkOutput("rst_score", int'(bus.score), 0);
        checkOutput("rst_level", int'(bus.level), 0);
        checkOutput("rst_hiscore", int'(bus.hiscore), 0);
        rst = 1'b0;

        $display("[TB] directed sequence");
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (6) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 42; i++) begin
            applyStimulus(i % 5 == 2, 1, 0, i % 7 == 3, 0);
        end
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (7) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] randomized sequence");
        for (int i = 0; i < 150; i++) begin
            bit s, hd, hb, hi, rr;
            s  = (m_mode != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            hd = ($urandom_range(0, 2) == 0);
            hb = ($urandom_range(0, 11) == 0);
            hi = ($urandom_range(0, 3) == 0);
            rr = !s && ($urandom_range(0, 59) == 0);
            applyStimulus(s, hd, hb, hi, rr);
        end

        repeat (3) begin
            @(posedge clk);
            #1;
            bus.hCount    = '0;
            bus.vCount    = '0;
            bus.start     = 1'b0;
            bus.rex_fill  = 1'b0;
            bus.obst_fill = 1'b0;
        end
        @(negedge clk);
        checkOutput("pending_ticks", exp_q.size(), 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
